// File: rtl/mdio_pkg.sv
// Shared constants for the MDIO responder: FSM states, frame codes and
// bit positions of each field inside the 32-bit frame (first bit = bit 31).
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SKIP,
    S_TA,
    S_WR_DATA,
    S_RD_DATA
  } state_e;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // Bit counts as 6-bit values so they compare directly against bit_cnt.
  localparam logic [5:0] FRAME_BITS = 6'd32;
  localparam logic [5:0] HDR_BITS   = 6'd14;
  localparam logic [5:0] TA_END     = 6'd16;

  // MSB position of each field within the frame shift register.
  localparam int ST_MSB   = 31;
  localparam int OP_MSB   = 29;
  localparam int PHY_MSB  = 27;
  localparam int REG_MSB  = 22;
  localparam int DATA_MSB = 15;

endpackage

// File: rtl/mdc_edge_det.sv
// Registers MDC once in the clk domain and flags its rising and falling edges.
module mdc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;
  logic mdc_d;

  // Next value of the delayed MDC copy.
  always_comb mdc_d = mdc;

  // One-stage delay used as the edge reference.
  always_ff @(posedge clk) begin
    if (rst) mdc_q <= 1'b0;
    else     mdc_q <= mdc_d;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side MDIO frame decoder: turns write frames into a register write
// strobe and answers read frames by shifting register data out MSB-first.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for the first driven MDC rise of a frame
// S_HEADER  | collecting ST, OP, PHYADDR, REGADDR (14 bits)
// S_SKIP    | frame for another PHY; consume the rest silently
// S_TA      | consuming the two turnaround bits
// S_WR_DATA | collecting 16 write data bits
// S_RD_DATA | responder drives read data, one bit per MDC fall
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         ADDR_W   = 5,
  parameter int         DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MDC,
  input  logic              mdio_oe,
  input  logic              mdio_out,
  output logic              mdio_in,
  output logic              mdio_drv,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              frame_err
);

  logic rise, fall;

  mdc_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .mdc  (MDC),
    .rise (rise),
    .fall (fall)
  );

  state_e            state_q, state_d;
  logic [31:0]       shift_q, shift_d, shift_smp;
  logic [5:0]        bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [4:0]        bit_pos;
  logic [DATA_W-1:0] rd_shift_q, rd_shift_d, rd_src;
  logic              first_fall_q, first_fall_d;
  logic              rd_cap_q, rd_cap_d;
  logic              mdio_in_q, mdio_in_d;
  logic              mdio_drv_q, mdio_drv_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              frame_err_q, frame_err_d;

  assign bit_pos = 5'd31 - bit_cnt_q[4:0];
  assign cnt_inc = bit_cnt_q + 6'd1;
  // Register data arrives one clk after capture is due; it can coincide with
  // the first MDC fall, so the fall path reads through this mux.
  assign rd_src  = rd_cap_q ? reg_rd_data : rd_shift_q;

  // Frame decode and next-state computation.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rd_shift_d   = rd_shift_q;
    first_fall_d = first_fall_q;
    rd_cap_d     = rd_en_q;
    mdio_in_d    = mdio_in_q;
    mdio_drv_d   = mdio_drv_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    frame_err_d  = 1'b0;

    shift_smp          = shift_q;
    shift_smp[bit_pos] = mdio_out;

    case (state_q)
      S_IDLE: begin
        mdio_drv_d = 1'b0;
        mdio_in_d  = 1'b0;
        if (rise && mdio_oe) begin
          shift_d     = '0;
          shift_d[31] = mdio_out;
          bit_cnt_d   = 6'd1;
          state_d     = S_HEADER;
        end
      end

      S_HEADER: begin
        if (rise) begin
          if (!mdio_oe) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = S_IDLE;
          end else begin
            shift_d   = shift_smp;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == HDR_BITS) begin
              if (shift_smp[ST_MSB -: 2] != ST_CODE ||
                  (shift_smp[OP_MSB -: 2] != OP_READ &&
                   shift_smp[OP_MSB -: 2] != OP_WRITE)) begin
                frame_err_d = 1'b1;
                bit_cnt_d   = '0;
                state_d     = S_IDLE;
              end else if (shift_smp[PHY_MSB -: 5] != PHY_ADDR) begin
                state_d = S_SKIP;
              end else begin
                state_d = S_TA;
              end
            end
          end
        end
      end

      S_SKIP: begin
        if (rise) begin
          bit_cnt_d = cnt_inc;
          if (!mdio_oe || cnt_inc == FRAME_BITS) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
      end

      S_TA: begin
        if (rise) begin
          if (!mdio_oe) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = S_IDLE;
          end else begin
            shift_d   = shift_smp;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == TA_END) begin
              if (shift_q[OP_MSB -: 2] == OP_READ) begin
                rd_en_d      = 1'b1;
                rd_addr_d    = shift_q[REG_MSB -: ADDR_W];
                mdio_drv_d   = 1'b1;
                first_fall_d = 1'b1;
                state_d      = S_RD_DATA;
              end else begin
                state_d = S_WR_DATA;
              end
            end
          end
        end
      end

      S_WR_DATA: begin
        if (rise) begin
          if (!mdio_oe) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            state_d     = S_IDLE;
          end else begin
            shift_d   = shift_smp;
            bit_cnt_d = cnt_inc;
            if (cnt_inc == FRAME_BITS) begin
              wr_en_d   = 1'b1;
              wr_addr_d = shift_smp[REG_MSB -: ADDR_W];
              wr_data_d = shift_smp[DATA_MSB -: DATA_W];
              bit_cnt_d = '0;
              state_d   = S_IDLE;
            end
          end
        end
      end

      S_RD_DATA: begin
        rd_shift_d = rd_src;
        if (fall) begin
          if (first_fall_q) begin
            mdio_in_d    = rd_src[DATA_W-1];
            first_fall_d = 1'b0;
          end else begin
            rd_shift_d = {rd_src[DATA_W-2:0], 1'b0};
            mdio_in_d  = rd_src[DATA_W-2];
          end
        end
        if (rise) begin
          bit_cnt_d = cnt_inc;
          if (cnt_inc == FRAME_BITS) begin
            mdio_drv_d = 1'b0;
            mdio_in_d  = 1'b0;
            bit_cnt_d  = '0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rd_shift_q   <= '0;
      first_fall_q <= 1'b0;
      rd_cap_q     <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_drv_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rd_shift_q   <= rd_shift_d;
      first_fall_q <= first_fall_d;
      rd_cap_q     <= rd_cap_d;
      mdio_in_q    <= mdio_in_d;
      mdio_drv_q   <= mdio_drv_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mdio_in   = mdio_in_q;
  assign mdio_drv  = mdio_drv_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: drives MDIO frames, hosts a 32x16 register file,
// and checks strobes and read data against a frame-level reference model.
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDC;
  logic        mdio_oe;
  logic        mdio_out;
  logic        mdio_in;
  logic        mdio_drv;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] reg_rd_data;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  int wr_cnt  = 0;
  int rd_cnt  = 0;
  int err_cnt = 0;
  int drv_cyc = 0;

  logic [15:0] mem     [32];
  logic [15:0] ref_mem [32];

  mdio_responder #(.PHY_ADDR(5'd1), .ADDR_W(5), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .MDC         (MDC),
    .mdio_oe     (mdio_oe),
    .mdio_out    (mdio_out),
    .mdio_in     (mdio_in),
    .mdio_drv    (mdio_drv),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .reg_rd_data (reg_rd_data),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Register file the responder talks to; read data valid the clk after rd_en.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) reg_rd_data <= mem[rd_addr];
  end

  // Pulse and drive-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en)     wr_cnt++;
    if (rd_en)     rd_cnt++;
    if (frame_err) err_cnt++;
    if (mdio_drv)  drv_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Generator: nbits MDC periods of 2*half clks. Data is driven while MDC is
  // low; read frames release the line from bit 16 and sample mdio_in on rises.
  task automatic send_frame(input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra,
                            input logic [15:0] data, input int half,
                            input int nbits, output logic [15:0] rbits);
    logic [31:0] frame;
    frame = {st, op, phy, ra, 2'b10, data};
    rbits = '0;
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MDC = 1'b0;
      if (op == 2'b10 && i >= 16) begin
        mdio_oe  = 1'b0;
        mdio_out = 1'b0;
      end else begin
        mdio_oe  = 1'b1;
        mdio_out = frame[31-i];
      end
      repeat (half) @(negedge clk);
      MDC = 1'b1;
      if (i >= 16) rbits[31-i] = mdio_in;
      repeat (half) @(negedge clk);
    end
    MDC      = 1'b0;
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
  endtask

  // One complete frame plus the model's verdict on what it must cause.
  task automatic do_frame(input string tag, input logic [1:0] st, input logic [1:0] op,
                          input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] data, input int half);
    logic        hdr_ok, hit, exp_wr, exp_rd, exp_err;
    int          w0, r0, e0, d0;
    logic [15:0] rbits;
    hdr_ok  = (st == 2'b01) && (op == 2'b10 || op == 2'b01);
    hit     = hdr_ok && (phy == 5'd1);
    exp_err = !hdr_ok;
    exp_wr  = hit && (op == 2'b01);
    exp_rd  = hit && (op == 2'b10);
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; d0 = drv_cyc;
    send_frame(st, op, phy, ra, data, half, hdr_ok ? 32 : 14, rbits);
    @(negedge clk);
    #1;
    chk({tag, ".wr_cnt"},  wr_cnt - w0,  {31'd0, exp_wr});
    chk({tag, ".rd_cnt"},  rd_cnt - r0,  {31'd0, exp_rd});
    chk({tag, ".err_cnt"}, err_cnt - e0, {31'd0, exp_err});
    chk({tag, ".drv_seen"}, {31'd0, (drv_cyc != d0)}, {31'd0, exp_rd});
    chk({tag, ".drv_end"}, {31'd0, mdio_drv}, 32'd0);
    if (exp_wr) begin
      chk({tag, ".wr_addr"}, {27'd0, wr_addr}, {27'd0, ra});
      chk({tag, ".wr_data"}, {16'd0, wr_data}, {16'd0, data});
      ref_mem[ra] = data;
    end
    if (exp_rd) begin
      chk({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, ra});
      chk({tag, ".rd_bits"}, {16'd0, rbits}, {16'd0, ref_mem[ra]});
    end
  endtask

  initial begin
    logic [15:0] dummy;
    logic [1:0]  st, op;
    logic [4:0]  phy, ra;
    logic [15:0] data;
    int          w0;

    for (int i = 0; i < 32; i++) begin
      mem[i]     = 16'h0;
      ref_mem[i] = 16'h0;
    end
    reg_rd_data = 16'h0;
    rst = 1'b1; MDC = 1'b0; mdio_oe = 1'b0; mdio_out = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset.outputs",
        {5'd0, mdio_in, mdio_drv, wr_en, wr_addr, rd_en, rd_addr, frame_err},
        32'd0);
    chk("reset.wr_data", {16'd0, wr_data}, 32'd0);

    // Directed frames.
    do_frame("wr_beef",  2'b01, 2'b01, 5'd1, 5'd3, 16'hBEEF, 2);
    do_frame("wr_a5c3",  2'b01, 2'b01, 5'd1, 5'd7, 16'hA5C3, 2);
    do_frame("rd_7",     2'b01, 2'b10, 5'd1, 5'd7, 16'h0000, 3);
    do_frame("wr_phy2",  2'b01, 2'b01, 5'd2, 5'd4, 16'h1111, 2);
    do_frame("wr_after", 2'b01, 2'b01, 5'd1, 5'd4, 16'h2222, 2);
    do_frame("rd_phy2",  2'b01, 2'b10, 5'd2, 5'd4, 16'h0000, 2);
    do_frame("bad_st",   2'b00, 2'b01, 5'd1, 5'd5, 16'h3333, 2);
    do_frame("bad_op",   2'b01, 2'b11, 5'd1, 5'd5, 16'h4444, 2);
    do_frame("rd_3",     2'b01, 2'b10, 5'd1, 5'd3, 16'h0000, 2);

    // Reset in the middle of a write frame (after bit 20).
    w0 = wr_cnt;
    send_frame(2'b01, 2'b01, 5'd1, 5'd9, 16'hDEAD, 2, 20, dummy);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mid.wr_cnt",  wr_cnt - w0, 32'd0);
    chk("rst_mid.wr_regs", {11'd0, wr_addr, wr_data}, 32'd0);
    chk("rst_mid.drv",     {31'd0, mdio_drv}, 32'd0);
    do_frame("wr_1234", 2'b01, 2'b01, 5'd1, 5'd0, 16'h1234, 2);

    // Back-to-back write then read at the minimum MDC period.
    do_frame("b2b_wr", 2'b01, 2'b01, 5'd1, 5'd12, 16'h5A0F, 2);
    do_frame("b2b_rd", 2'b01, 2'b10, 5'd1, 5'd12, 16'h0000, 2);
    do_frame("rd_0",   2'b01, 2'b10, 5'd1, 5'd0, 16'h0000, 2);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      st   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b01;
      op   = 2'($urandom);
      phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
      ra   = 5'($urandom_range(0, 7));
      data = 16'($urandom);
      do_frame($sformatf("rnd%0d", n), st, op, phy, ra, data, $urandom_range(2, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side end of the MDIO management link. Receives the serial frames produced by the MDIO generator on MDC/mdio_out/mdio_oe.
- Decodes each frame as ST, OP, PHYADDR, REGADDR, TA and DATA.
- Write frames produce a single-cycle register write strobe.
- Read frames fetch a register value and shift it back MSB-first on mdio_in.
- Sits between the generator and a 32x16 PHY register file in the testbench/top level.

Parameters:
- PHY_ADDR, 5'd1, address this responder answers to; frames for other addresses are consumed silently.
- ADDR_W, 5, register address width (fixed by the frame format).
- DATA_W, 16, register data width (fixed by the frame format).

Ports:
- clk  input  1  system clock; all logic is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- MDC  input  1  management clock from the generator, sampled as data; period >= 4 clk.
- mdio_oe  input  1  generator output enable; bits are valid only while it is high.
- mdio_out  input  1  serial data from the generator.
- mdio_in  output  1  serial read data returned to the generator.
- mdio_drv  output  1  high while the responder owns the data line (read data phase).
- wr_en  output  1  one-clk write strobe.
- wr_addr  output  5  register address for the write.
- wr_data  output  16  register data for the write.
- rd_en  output  1  one-clk read request.
- rd_addr  output  5  register address for the read.
- reg_rd_data  input  16  register file data, valid the clk after rd_en.
- frame_err  output  1  one-clk pulse when a frame is aborted.

Behaviour:
- Reset: every output is 0, state is IDLE, shift registers and counters are 0. Reset mid-frame discards the frame; no strobe is issued.
- MDC edge detection:
  - mdc_q is MDC registered once.
  - rise = MDC & ~mdc_q; fall = ~MDC & mdc_q.
  - All bit events happen on the clk cycle where rise or fall is high.
- Sampling: on rise with mdio_oe=1, shift mdio_out into a 32-bit shift register MSB-first and increment bit_cnt (6 bits).
- IDLE:
  - The first rise with mdio_oe=1 loads bit 31, sets bit_cnt=1 and moves to HEADER.
  - A rise with mdio_oe=0 is ignored.
- HEADER: collect bits until bit_cnt=14 (ST[1:0], OP[1:0], PHYADDR[4:0], REGADDR[4:0]), then check:
  - ST != 2'b01, or OP not in {2'b10 read, 2'b01 write}: pulse frame_err, go to IDLE.
  - PHYADDR != PHY_ADDR: go to SKIP. SKIP consumes the remaining 18 rises, or exits early when mdio_oe is low on a rise, then returns to IDLE with no strobe.
  - Otherwise go to TA.
- TA: consume 2 bits (bit_cnt 15..16). TA content is not checked.
  - Read: pulse rd_en with rd_addr=REGADDR on the clk after the 16th rise, capture reg_rd_data on the next clk, go to RD_DATA.
  - Write: go to WR_DATA.
- WR_DATA:
  - Collect 16 bits.
  - On the clk after the 32nd rise: wr_en=1 for exactly one clk, wr_addr=REGADDR, wr_data=bits[15:0]; return to IDLE.
  - If mdio_oe is low on a rise before bit 32: pulse frame_err, go to IDLE, no write.
- RD_DATA:
  - mdio_drv=1.
  - The first fall places rd_shift[15] on mdio_in; each later fall shifts left one bit.
  - Every rise counts one bit; mdio_oe is ignored in this state.
  - After the 16th rise (bit_cnt=32): mdio_drv=0, mdio_in=0, return to IDLE.
- Outputs:
  - wr_en, rd_en and frame_err are single-clk pulses.
  - wr_addr, wr_data and rd_addr hold their values until the next strobe.
- rise and fall in the same clk cannot occur. A new frame is not accepted until the state is IDLE.

Decomposition:
- Package mdio_pkg: state encoding (IDLE, HEADER, SKIP, TA, WR_DATA, RD_DATA), ST_CODE=2'b01, OP_READ=2'b10, OP_WRITE=2'b01, field bit positions, FRAME_BITS=32, HDR_BITS=14.
- One sub-module, mdc_edge_det: registers MDC and outputs rise/fall pulses.

Test Plan:
- Write frame 0x5 | PHYADDR 1, REGADDR 3, TA 2'b10, DATA 0xBEEF -> exactly one wr_en pulse with wr_addr=3, wr_data=0xBEEF; mdio_drv stays 0.
- Read frame, REGADDR 7, reg_rd_data=0xA5C3 -> one rd_en pulse with rd_addr=7; the bits sampled on the next 16 MDC rises read 0xA5C3; mdio_drv falls after the last bit.
- Write frame with PHYADDR 2 -> no wr_en, no frame_err, next valid frame accepted normally.
- Frame with ST=2'b00, then frame with OP=2'b11 -> one frame_err pulse per frame, no strobes, return to IDLE.
- Reset asserted at bit 20 of a write, then a fresh write to REGADDR 0 with 0x1234 -> no strobe from the aborted frame, then wr_en with wr_data=0x1234.
- Back-to-back write then read with MDC period 4 clk -> both complete; no extra or missing strobes.
